// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester round-robin arbiter and sequencer for the single-port data RAM.
//   Port 0 is the core load/store unit, port 1 is the DMA/debug/init master.
//   One access is in flight at a time: the winner is latched in IDLE, the RAM is
//   driven for exactly one BUSY cycle, and a one-cycle ack (with registered read
//   data) follows in the next cycle.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req/we/addr/wdata 0|1 requester side; req held until the matching ack
//   ack/rdata/err 0|1     completion pulse, registered read data, range error
//   ram_*                 single-port RAM interface (ram_rdata is a comb read)
//
// Configuration
//   DMEM_ARB_ADDR_CHECK_EN  when defined, latched byte addresses >= 4*DEPTH are
//                           rejected: RAM enables stay low, ack pulses with err,
//                           and reads return all-E data. Undefined: err is 0 and
//                           addresses pass through unchecked.
//
// State | meaning
// IDLE  | pick an eligible requester and latch its access
// BUSY  | RAM driven from latched regs; capture read data, schedule ack
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  err0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err1,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_write_en,
    output logic                  ram_read_en,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * DEPTH);

    logic [0:0]            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic                  elig0, elig1, grant1, busy;
    logic                  addr_oor;
    logic [DATA_WIDTH-1:0] rd_capture;

`ifdef DMEM_ARB_ADDR_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = {(DATA_WIDTH/4){4'hE}};
    assign addr_oor   = (addr_q >= ADDR_LIMIT);
    assign rd_capture = addr_oor ? ERR_DATA : ram_rdata;
`else
    // Range compare kept only so DEPTH stays referenced in the unchecked build.
    logic depth_chk_unused;
    assign depth_chk_unused = (addr_q >= ADDR_LIMIT);
    assign addr_oor   = 1'b0;
    assign rd_capture = ram_rdata;
`endif

    // A requester is ignored during its own ack cycle so a still-high req is
    // not granted a second time before it has had a chance to drop.
    assign elig0  = req0 & ~ack0_q;
    assign elig1  = req1 & ~ack1_q;
    assign grant1 = elig1 & (~elig0 | ~last_grant_q);
    assign busy   = (state_q == ST_BUSY);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elig0 | elig1) begin
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    we_d         = grant1 ? we1    : we0;
                    addr_d       = grant1 ? addr1  : addr0;
                    wdata_d      = grant1 ? wdata1 : wdata0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                state_d = ST_IDLE;
                if (owner_q) begin
                    ack1_d = 1'b1;
                    err1_d = addr_oor;
                    if (!we_q) rdata1_d = rd_capture;
                end else begin
                    ack0_d = 1'b1;
                    err0_d = addr_oor;
                    if (!we_q) rdata0_d = rd_capture;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Enables decode straight from state so leaving BUSY can never leave a
    // write strobe hanging into IDLE.
    assign ram_write_en = busy & we_q & ~addr_oor;
    assign ram_read_en  = busy & ~we_q & ~addr_oor;
    assign ram_address  = busy ? addr_q  : '0;
    assign ram_wdata    = busy ? wdata_q : '0;

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule
